// File: rtl/aes_loader_pkg.sv
// Shared types and sizing helpers for the AES frame loader.
package aes_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_DATA = 2'd0,
    LOAD_KEY  = 2'd1,
    HOLD      = 2'd2,
    WAIT_DEC  = 2'd3
  } loader_state_e;

  localparam int BLOCK_BYTES   = 16;
  localparam int FRAME_COUNT_W = 16;

  function automatic int key_bytes(input int nk);
    return nk * 4;
  endfunction

  // Byte counter must address the longer of the block and the key.
  function automatic int cnt_width(input int nk);
    return (key_bytes(nk) > BLOCK_BYTES) ? $clog2(key_bytes(nk)) : $clog2(BLOCK_BYTES);
  endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// Wide big-endian register written one addressed byte at a time;
// byte k lands at word_o[8k:8k+7] with byte_i[7] at the lowest index.
module aes_byte_shifter #(
  parameter int BYTES = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [7:0]         byte_i,
  output logic [0:BYTES*8-1] word_o
);

  logic [0:BYTES*8-1] word_q;

  // Byte-lane write; unaddressed lanes keep their previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      for (int i = 0; i < BYTES; i++) begin
        if (we_i && (int'(addr_i) == i)) begin
          word_q[i*8 +: 8] <= byte_i;
        end
      end
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/aes_frame_loader.sv
// Assembles a 128-bit block and Nk-word key from a byte stream and holds them for one
// encrypt+decrypt round trip. Define LOADER_TIMEOUT_EN to abort stalled partial frames.
module aes_frame_loader
  import aes_loader_pkg::*;
#(
  parameter int Nk            = 4,
  parameter int FRAME_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  input  logic                     done_enc,
  input  logic                     done_dec,
  output logic [0:127]             data_out,
  output logic [0:Nk*32-1]         key_out,
  output logic                     frame_valid,
  output logic                     busy,
  output logic [FRAME_COUNT_W-1:0] frame_count,
  output logic                     err_timeout
);

  localparam int KEY_BYTES = key_bytes(Nk);
  localparam int CW        = cnt_width(Nk);

  localparam logic [CW-1:0]            LAST_DATA = CW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0]            LAST_KEY  = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0]            CNT_ONE   = CW'(1);
  localparam logic [FRAME_COUNT_W-1:0] FC_ONE    = FRAME_COUNT_W'(1);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_frame_loader: Nk must be 4, 6 or 8");
  end
  if (FRAME_TIMEOUT < 1) begin : g_bad_timeout
    $error("aes_frame_loader: FRAME_TIMEOUT must be at least 1");
  end

  loader_state_e            state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     fv_q, fv_d;
  logic                     busy_q, busy_d;
  logic [FRAME_COUNT_W-1:0] fcount_q, fcount_d;
  logic                     ready_q, ready_d;
  logic                     xfer_s;
  logic                     data_we_s, key_we_s;

  assign xfer_s    = byte_valid && ready_q;
  assign data_we_s = xfer_s && (state_q == LOAD_DATA);
  assign key_we_s  = xfer_s && (state_q == LOAD_KEY);

`ifdef LOADER_TIMEOUT_EN
  localparam int              IW        = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [IW-1:0]   IDLE_LAST = IW'(FRAME_TIMEOUT - 1);
  localparam logic [IW-1:0]   IDLE_ONE  = IW'(1);
  logic [IW-1:0] idle_q, idle_d;
  logic          err_q, err_d;
`endif

  // Next-state, byte counter and frame status.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fv_d     = fv_q;
    busy_d   = busy_q;
    fcount_d = fcount_q;
    case (state_q)
      LOAD_DATA: begin
        if (xfer_s) begin
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = LOAD_KEY;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      LOAD_KEY: begin
        if (xfer_s) begin
          if (cnt_q == LAST_KEY) begin
            cnt_d   = '0;
            state_d = HOLD;
            fv_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      // A lone done_dec here is out of order and dropped.
      HOLD: begin
        if (done_enc && done_dec) begin
          state_d  = LOAD_DATA;
          cnt_d    = '0;
          fv_d     = 1'b0;
          busy_d   = 1'b0;
          fcount_d = fcount_q + FC_ONE;
        end else if (done_enc) begin
          state_d = WAIT_DEC;
        end else begin
          state_d = HOLD;
        end
      end
      WAIT_DEC: begin
        if (done_dec) begin
          state_d  = LOAD_DATA;
          cnt_d    = '0;
          fv_d     = 1'b0;
          busy_d   = 1'b0;
          fcount_d = fcount_q + FC_ONE;
        end else begin
          state_d = WAIT_DEC;
        end
      end
      default: begin
        state_d = LOAD_DATA;
        cnt_d   = '0;
      end
    endcase

`ifdef LOADER_TIMEOUT_EN
    idle_d = idle_q;
    err_d  = err_q;
    if (!xfer_s && ((state_q == LOAD_KEY) || ((state_q == LOAD_DATA) && (cnt_q != '0)))) begin
      if (idle_q == IDLE_LAST) begin
        idle_d  = '0;
        state_d = LOAD_DATA;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_ONE;
      end
    end else begin
      idle_d = '0;
    end
`endif

    ready_d = (state_d == LOAD_DATA) || (state_d == LOAD_KEY);
  end

  // State and status registers; byte_ready stays low while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD_DATA;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      fcount_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      busy_q   <= busy_d;
      fcount_q <= fcount_d;
      ready_q  <= ready_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Idle watchdog and sticky abort flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  aes_byte_shifter #(
    .BYTES (BLOCK_BYTES),
    .AW    (CW)
  ) u_data_shifter (
    .clk    (clk),
    .rst    (rst),
    .we_i   (data_we_s),
    .addr_i (cnt_q),
    .byte_i (byte_in),
    .word_o (data_out)
  );

  aes_byte_shifter #(
    .BYTES (KEY_BYTES),
    .AW    (CW)
  ) u_key_shifter (
    .clk    (clk),
    .rst    (rst),
    .we_i   (key_we_s),
    .addr_i (cnt_q),
    .byte_i (byte_in),
    .word_o (key_out)
  );

  assign byte_ready  = ready_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_aes_frame_loader.sv
// Self-checking bench for aes_frame_loader: an Nk=4 instance (FRAME_TIMEOUT=8) and an Nk=8 instance.
module tb_aes_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]   a_byte;
  logic         a_valid, a_ready, a_enc, a_dec, a_fv, a_busy, a_err;
  logic [0:127] a_data;
  logic [0:127] a_key;
  logic [15:0]  a_cnt;

  logic [7:0]   b_byte;
  logic         b_valid, b_ready, b_enc, b_dec, b_fv, b_busy, b_err;
  logic [0:127] b_data;
  logic [0:255] b_key;
  logic [15:0]  b_cnt;

  aes_frame_loader #(.Nk(4), .FRAME_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .byte_in(a_byte), .byte_valid(a_valid), .byte_ready(a_ready),
    .done_enc(a_enc), .done_dec(a_dec), .data_out(a_data), .key_out(a_key),
    .frame_valid(a_fv), .busy(a_busy), .frame_count(a_cnt), .err_timeout(a_err)
  );

  aes_frame_loader #(.Nk(8)) dut_b (
    .clk(clk), .rst(rst), .byte_in(b_byte), .byte_valid(b_valid), .byte_ready(b_ready),
    .done_enc(b_enc), .done_dec(b_dec), .data_out(b_data), .key_out(b_key),
    .frame_valid(b_fv), .busy(b_busy), .frame_count(b_cnt), .err_timeout(b_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: byte arrays in stream order plus round-trip bookkeeping.
  logic [7:0] ma_data [16];
  logic [7:0] ma_key  [16];
  int         ma_pos, ma_count;
  bit         ma_hold, ma_enc_seen;
  logic [7:0] mb_data [16];
  logic [7:0] mb_key  [32];
  int         mb_pos;

  function automatic logic [127:0] exp_a_data();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], ma_data[i]};
    return v;
  endfunction
  function automatic logic [127:0] exp_a_key();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], ma_key[i]};
    return v;
  endfunction
  function automatic logic [127:0] exp_b_data();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], mb_data[i]};
    return v;
  endfunction
  function automatic logic [255:0] exp_b_key();
    logic [255:0] v = '0;
    for (int i = 0; i < 32; i++) v = {v[247:0], mb_key[i]};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin ma_data[i] = 8'h00; ma_key[i] = 8'h00; mb_data[i] = 8'h00; end
    for (int i = 0; i < 32; i++) mb_key[i] = 8'h00;
    ma_pos = 0; ma_count = 0; ma_hold = 1'b0; ma_enc_seen = 1'b0; mb_pos = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b, input int maxgap);
    int gap;
    int guard;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    if (gap > 0) begin
      a_valid = 1'b0;
      repeat (gap) tick();
    end
    a_byte = b;
    a_valid = 1'b1;
    guard = 0;
    while (a_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL send_a_ready_timeout actual=%b required=1", a_ready);
    end
    tick();
    if (ma_pos < 16) ma_data[ma_pos] = b; else ma_key[ma_pos-16] = b;
    ma_pos++;
    if (ma_pos == 32) begin ma_pos = 0; ma_hold = 1'b1; end
  endtask

  task automatic send_b(input logic [7:0] b, input int maxgap);
    int gap;
    int guard;
    gap = int'($urandom_range(maxgap, 0));
    if (gap > 0) begin
      b_valid = 1'b0;
      repeat (gap) tick();
    end
    b_byte = b;
    b_valid = 1'b1;
    guard = 0;
    while (b_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL send_b_ready_timeout actual=%b required=1", b_ready);
    end
    tick();
    if (mb_pos < 16) mb_data[mb_pos] = b; else mb_key[mb_pos-16] = b;
    mb_pos++;
  endtask

  task automatic pulse_a(input bit enc, input bit dec);
    a_enc = enc; a_dec = dec;
    tick();
    a_enc = 1'b0; a_dec = 1'b0;
    if (ma_hold) begin
      if (dec && (enc || ma_enc_seen)) begin
        ma_hold = 1'b0; ma_enc_seen = 1'b0; ma_count = (ma_count + 1) % 65536;
      end else if (enc) begin
        ma_enc_seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_byte = 8'h00; a_valid = 1'b0; a_enc = 1'b0; a_dec = 1'b0;
    b_byte = 8'h00; b_valid = 1'b0; b_enc = 1'b0; b_dec = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({a_data, a_key} !== 256'd0) begin errors++; $display("FAIL reset_words actual=%h required=0", {a_data, a_key}); end
    checks++;
    if ({a_fv, a_busy, a_cnt, a_err, a_ready} !== 20'd0) begin
      errors++; $display("FAIL reset_status actual=%h required=0", {a_fv, a_busy, a_cnt, a_err, a_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin errors++; $display("FAIL ready_after_reset actual=%b required=11", {a_ready, b_ready}); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 32; i++) send_a(8'(i), 0);
    a_valid = 1'b0;
    checks++;
    if (a_data !== 128'h000102030405060708090a0b0c0d0e0f) begin
      errors++; $display("FAIL stream_data actual=%h required=000102..0f", a_data);
    end
    checks++;
    if (a_key !== 128'h101112131415161718191a1b1c1d1e1f) begin
      errors++; $display("FAIL stream_key actual=%h required=101112..1f", a_key);
    end
    checks++;
    if ({a_fv, a_busy, a_ready} !== 3'b110) begin errors++; $display("FAIL stream_hold_flags actual=%b required=110", {a_fv, a_busy, a_ready}); end
    a_byte = 8'hEE; a_valid = 1'b1;
    repeat (3) tick();
    a_valid = 1'b0;
    checks++;
    if (a_ready !== 1'b0 || a_data !== exp_a_data() || a_key !== exp_a_key()) begin
      errors++; $display("FAIL extra_byte_rejected actual ready=%b data=%h required ready=0 data=%h", a_ready, a_data, exp_a_data());
    end
  endtask

  task automatic test_done_order();
    pulse_a(1'b0, 1'b1);
    checks++;
    if ({a_fv, a_cnt} !== {1'b1, 16'd0}) begin errors++; $display("FAIL lone_dec_ignored actual fv=%b cnt=%0d required fv=1 cnt=0", a_fv, a_cnt); end
    pulse_a(1'b1, 1'b0);
    checks++;
    if ({a_fv, a_busy} !== 2'b11) begin errors++; $display("FAIL enc_keeps_hold actual=%b required=11", {a_fv, a_busy}); end
    pulse_a(1'b0, 1'b1);
    checks++;
    if ({a_fv, a_busy, a_ready, a_cnt} !== {3'b001, 16'(ma_count)}) begin
      errors++; $display("FAIL frame_complete actual fv/busy/ready=%b cnt=%0d required 001 cnt=%0d", {a_fv, a_busy, a_ready}, a_cnt, ma_count);
    end
  endtask

  task automatic test_partial_retain_and_same_cycle();
    for (int i = 0; i < 5; i++) send_a(8'($urandom), 2);
    a_valid = 1'b0;
    checks++;
    if (a_data !== exp_a_data() || a_fv !== 1'b0) begin
      errors++; $display("FAIL partial_retain actual=%h fv=%b required=%h fv=0", a_data, a_fv, exp_a_data());
    end
    for (int i = 5; i < 32; i++) send_a(8'($urandom), 2);
    a_valid = 1'b0;
    checks++;
    if (a_data !== exp_a_data() || a_key !== exp_a_key() || a_fv !== 1'b1) begin
      errors++; $display("FAIL random_frame actual=%h/%h fv=%b required=%h/%h fv=1", a_data, a_key, a_fv, exp_a_data(), exp_a_key());
    end
    pulse_a(1'b1, 1'b1);
    checks++;
    if ({a_fv, a_cnt} !== {1'b0, 16'(ma_count)} || ma_count != 2) begin
      errors++; $display("FAIL same_cycle_done actual fv=%b cnt=%0d required fv=0 cnt=2", a_fv, a_cnt);
    end
  endtask

  task automatic test_nk8();
    for (int i = 0; i < 48; i++) send_b(8'($urandom), 3);
    b_valid = 1'b0;
    checks++;
    if (b_data !== exp_b_data() || b_key !== exp_b_key()) begin
      errors++; $display("FAIL nk8_words actual=%h/%h required=%h/%h", b_data, b_key, exp_b_data(), exp_b_key());
    end
    checks++;
    if ({b_fv, b_busy, b_ready} !== 3'b110) begin errors++; $display("FAIL nk8_hold_flags actual=%b required=110", {b_fv, b_busy, b_ready}); end
    b_byte = 8'h5A; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (b_ready !== 1'b0 || b_key !== exp_b_key()) begin errors++; $display("FAIL nk8_byte49 actual ready=%b required ready=0", b_ready); end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 10; i++) send_a(8'($urandom), 1);
    a_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({a_data, a_key, a_fv, a_busy, a_cnt, a_err, a_ready} !== 276'd0) begin
      errors++; $display("FAIL midframe_reset_a actual data=%h key=%h cnt=%0d ready=%b required all 0", a_data, a_key, a_cnt, a_ready);
    end
    checks++;
    if ({b_data, b_key, b_fv, b_busy, b_cnt, b_ready} !== 403'd0) begin
      errors++; $display("FAIL midframe_reset_b actual fv=%b key=%h required all 0", b_fv, b_key);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) send_a(8'($urandom), 1);
    a_valid = 1'b0;
    checks++;
    if (a_data !== exp_a_data() || a_key !== exp_a_key() || a_fv !== 1'b1) begin
      errors++; $display("FAIL post_reset_frame actual=%h/%h fv=%b required=%h/%h", a_data, a_key, a_fv, exp_a_data(), exp_a_key());
    end
    pulse_a(1'b1, 1'b1);
    checks++;
    if (a_cnt !== 16'(ma_count)) begin errors++; $display("FAIL post_reset_count actual=%0d required=%0d", a_cnt, ma_count); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 32; i++) send_a(8'($urandom), (f % 2 == 0) ? 0 : 2);
      a_valid = 1'b0;
      checks++;
      if (a_data !== exp_a_data() || a_key !== exp_a_key()) begin
        errors++; $display("FAIL b2b_words frame=%0d actual=%h/%h required=%h/%h", f, a_data, a_key, exp_a_data(), exp_a_key());
      end
      for (int p = 0; p < 12 && ma_hold; p++) begin
        pulse_a(1'($urandom), 1'($urandom));
        checks++;
        if ({a_fv, a_busy, a_cnt} !== {ma_hold, ma_hold, 16'(ma_count)}) begin
          errors++; $display("FAIL b2b_done frame=%0d actual fv=%b cnt=%0d required fv=%b cnt=%0d", f, a_fv, a_cnt, ma_hold, ma_count);
        end
      end
      if (ma_hold) pulse_a(1'b1, 1'b1);
      checks++;
      if ({a_fv, a_ready, a_cnt} !== {2'b01, 16'(ma_count)}) begin
        errors++; $display("FAIL b2b_end frame=%0d actual fv=%b ready=%b cnt=%0d required fv=0 ready=1 cnt=%0d", f, a_fv, a_ready, a_cnt, ma_count);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) send_a(8'($urandom), 0);
    a_valid = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    repeat (7) tick();
    checks++;
    if (a_err !== 1'b0) begin errors++; $display("FAIL timeout_early actual=%b required=0", a_err); end
    tick();
    ma_pos = 0;
    checks++;
    if ({a_err, a_ready, a_fv} !== 3'b110 || a_data !== exp_a_data()) begin
      errors++; $display("FAIL timeout_abort actual err/ready/fv=%b data=%h required 110 data=%h", {a_err, a_ready, a_fv}, a_data, exp_a_data());
    end
    for (int i = 0; i < 32; i++) send_a(8'($urandom), 1);
`else
    repeat (40) tick();
    checks++;
    if ({a_err, a_ready, a_fv} !== 3'b010) begin errors++; $display("FAIL no_timeout actual=%b required=010", {a_err, a_ready, a_fv}); end
    for (int i = 5; i < 32; i++) send_a(8'($urandom), 1);
`endif
    a_valid = 1'b0;
    checks++;
    if (a_data !== exp_a_data() || a_key !== exp_a_key() || a_fv !== 1'b1) begin
      errors++; $display("FAIL frame_after_idle actual=%h/%h fv=%b required=%h/%h fv=1", a_data, a_key, a_fv, exp_a_data(), exp_a_key());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_done_order();
    test_partial_retain_and_same_cycle();
    test_nk8();
    test_reset_midframe();
    test_back_to_back();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_frame_loader.md
Name: aes_frame_loader

Overview:
- Upstream feeder for the SPI master / AES slave pair.
- Accepts a byte stream from a host interface (UART/bridge) over a valid/ready handshake.
- Assembles a 128-bit plaintext block plus an Nk*32-bit key.
- Presents block and key as stable parallel words, holds them through one encrypt+decrypt round trip (done_enc then done_dec), then accepts the next frame.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8); key byte count = Nk*4.
- FRAME_TIMEOUT, 1024, idle cycles allowed between bytes of a partial frame (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_in  in  8  stream byte, bit 7 = first bit in block order.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader can accept a byte.
- done_enc  in  1  single-cycle pulse: encryption readback complete.
- done_dec  in  1  single-cycle pulse: decryption readback complete.
- data_out  out  128 [0:127]  plaintext block; index 0 is the first bit the master shifts.
- key_out  out  Nk*32 [0:Nk*32-1]  key; index 0 is the first key bit shifted.
- frame_valid  out  1  data_out/key_out complete and stable.
- busy  out  1  frame_valid held, awaiting done pulses.
- frame_count  out  16  completed round trips, wraps 0xFFFF->0.
- err_timeout  out  1  sticky partial-frame abort flag.

Behaviour:
- Reset (async): state=LOAD_DATA, byte counter=0, data_out=0, key_out=0, frame_valid=0, busy=0, frame_count=0, err_timeout=0, byte_ready=0 while rst high; byte_ready=1 from the first clk edge after release.
- Transfer occurs on a rising edge with byte_valid && byte_ready. byte_ready is registered and does not combinationally depend on byte_valid.
- LOAD_DATA:
  - Byte k (0..15) is written to data_out[8k:8k+7], byte_in[7] -> data_out[8k].
  - After byte 15: counter=0, go to LOAD_KEY.
- LOAD_KEY:
  - Byte k (0..Nk*4-1) is written to key_out[8k:8k+7], same bit order.
  - After the last key byte, go to HOLD. frame_valid=1 and busy=1 on the same edge. byte_ready=0 from the next cycle, so no byte beyond the frame is accepted.
- HOLD:
  - done_enc -> WAIT_DEC.
  - done_dec alone is ignored (out of order).
  - done_enc and done_dec in the same cycle completes the frame as in WAIT_DEC.
- WAIT_DEC: done_dec completes the frame; extra done_enc is ignored.
- Frame completion (one edge): frame_valid=0, busy=0, frame_count+1 (wrapping), state=LOAD_DATA, counter=0, byte_ready=1 from the next cycle.
- data_out/key_out retain their old values until overwritten byte by byte. Partially loaded words are not cleared.
- Latency: the last key byte handshake to frame_valid=1 is 1 edge; done_dec to byte_ready=1 is 1 edge.
- Outputs are modified only in the LOAD states, so the words are stable whenever frame_valid=1.
- rst mid-frame or mid-hold returns everything to reset values immediately. The downstream master is reset by the same rst.
- Counter width is clog2(max(16, Nk*4)). Out-of-range Nk (not 4/6/8) is a compile-time error.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- With it:
  - An idle counter runs in LOAD_DATA/LOAD_KEY whenever counter!=0 or state=LOAD_KEY, and clears on each accepted byte.
  - On reaching FRAME_TIMEOUT, the partial frame is aborted: state=LOAD_DATA, counter=0, err_timeout=1 (sticky until rst). data_out/key_out are left as-is and frame_valid stays 0.
- Without it: no idle counter; a frame waits indefinitely; err_timeout is tied 0.

Decomposition:
- Shared package aes_loader_pkg:
  - state enum (LOAD_DATA, LOAD_KEY, HOLD, WAIT_DEC);
  - BLOCK_BYTES=16;
  - function key_bytes(Nk);
  - FRAME_COUNT_W=16.
- One natural sub-module: aes_byte_shifter, which writes an addressed byte into a wide big-endian register. It is instantiated twice (data and key).
- The FSM and counters stay in the top.

Test Plan:
- Nk=4: stream bytes 0x00..0x1F with byte_valid continuously high -> after 32 handshakes, data_out=0x000102..0F, key_out=0x101112..1F, frame_valid=1 one edge later, byte_ready=0.
- In HOLD, pulse done_dec then done_enc then done_dec -> first done_dec ignored; frame completes on the second done_dec; frame_count=1; byte_ready=1 the next cycle.
- Nk=8, random byte_valid gaps -> 48 bytes accepted, key_out[0:255] matches the stream order; a 49th byte offered in HOLD is not accepted (byte_ready=0).
- Assert rst after 10 data bytes -> all outputs 0 immediately; a fresh 32-byte frame loads correctly afterward.
- done_enc and done_dec in the same cycle in HOLD -> frame completes, frame_count increments by exactly 1.
- With LOADER_TIMEOUT_EN and FRAME_TIMEOUT=8: send 5 bytes, then idle 8 cycles -> err_timeout=1, state LOAD_DATA; the next 32 bytes form a full valid frame. Preload frame_count=0xFFFF via 65535 trips -> wraps to 0.
